// File: rtl/mux16_rr_scheduler.sv
// Round-robin sequencer for a shared 16:1 32-bit mux: picks a lane, drives the
// mux select and grants up to BURST accepted beats per tenure.
module mux16_rr_scheduler #(
    parameter int unsigned BURST = 4,
    parameter int unsigned CNT_W = (BURST > 1) ? $clog2(BURST) : 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] req,
    input  logic [15:0] en_mask,
    input  logic        out_ready,
    output logic [3:0]  sel,
    output logic        out_valid,
    output logic [15:0] grant,
    output logic        busy
);

    typedef enum logic {StIdle, StServe} state_e;

    state_e           state_q, state_d;
    logic [3:0]       sel_q, sel_d;
    logic [3:0]       ptr_q, ptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [15:0]      elig;
    logic [3:0]       pick;
    logic [3:0]       lane;
    logic             found;
    logic             accept;
    logic             last_beat;

    assign elig = req & en_mask;

    // Circular priority scan starting at ptr_q; first eligible lane wins.
    always_comb begin
        pick  = ptr_q;
        found = 1'b0;
        lane  = '0;
        for (int i = 0; i < 16; i++) begin
            lane = ptr_q + 4'(i);
            if (!found && elig[lane]) begin
                pick  = lane;
                found = 1'b1;
            end
        end
    end

    assign out_valid = (state_q == StServe) && req[sel_q] && en_mask[sel_q];
    assign accept    = out_valid && out_ready;
    assign last_beat = (cnt_q == CNT_W'(BURST - 1));
    assign grant     = accept ? (16'h0001 << sel_q) : 16'h0000;
    assign busy      = (state_q == StServe);
    assign sel       = sel_q;

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            StIdle: begin
                if (found) begin
                    sel_d   = pick;
                    cnt_d   = '0;
                    state_d = StServe;
                end
            end
            StServe: begin
                // A dropped or masked lane forfeits the rest of its tenure.
                if (!out_valid || (accept && last_beat)) begin
                    state_d = StIdle;
                    ptr_d   = sel_q + 4'd1;
                end else if (accept) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            sel_q   <= '0;
            ptr_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule
